// File: rtl/v_tile_result_router.sv
// Result router behind v_tile: buffers tagged result vectors in a FIFO and
// forwards each head entry to one, all or none of the neighbouring tiles.

module v_tile_result_router_port (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic target,
    input  logic ack,
    output logic en,
    output logic done_next
);
    logic done;

    // A non-targeted port counts as done from the start of the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            en   <= target;
            done <= !target;
        end else if (en && ack) begin
            en   <= 1'b0;
            done <= 1'b1;
        end
    end

    assign done_next = done | (en & ack);
endmodule

module v_tile_result_router #(
    parameter int width      = 16,
    parameter int num_inputs = 4,
    parameter int depth      = 4,
    parameter int num_dests  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [num_inputs-1:0][width-1:0]    adder_outputs,
    input  logic [3:0]                          dest_info,
    input  logic                                adder_ack,
    output logic                                res_rdy,
    output logic [num_inputs-1:0][width-1:0]    w_data_out,
    output logic [num_dests-1:0]                write_en,
    input  logic [num_dests-1:0]                write_rdy,
    input  logic [num_dests-1:0]                write_ack,
    output logic [$clog2(depth):0]              occupancy,
    output logic                                route_err
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [num_inputs-1:0][width-1:0] data;
        logic [3:0]                       tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND} state_t;

    entry_t                 mem [depth];
    entry_t                 head;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop, empty;
    logic [1:0]             idx;
    logic                   head_bad, head_discard;
    logic [num_dests-1:0]   head_mask, tmask, done_next;
    logic                   load, start;
    state_t                 state, state_nxt;

    assign res_rdy = occupancy != CW'(depth);
    assign empty   = occupancy == '0;
    assign push    = adder_ack && res_rdy;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: adder_outputs, tag: dest_info};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: ;
            endcase
        end
    end

    // Discard bit dominates; an out-of-range unicast index degrades to discard.
    assign idx          = head.tag[1:0];
    assign head_bad     = !head.tag[3] && !head.tag[2] && (int'(idx) >= num_dests);
    assign head_discard = head.tag[3] || head_bad;
    assign head_mask    = head.tag[2] ? '1 : (num_dests'(1) << idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                load = 1'b1;
                if (head_discard) pop = 1'b1;
                else              state_nxt = WAIT_RDY;
            end
            WAIT_RDY: if ((write_rdy & tmask) == tmask) begin
                start     = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (&done_next) begin
                pop       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_data_out <= '0;
            tmask      <= '0;
            route_err  <= 1'b0;
        end else if (load) begin
            w_data_out <= head.data;
            tmask      <= head_mask;
            if (head_bad) route_err <= 1'b1;
        end
    end

    for (genvar d = 0; d < num_dests; d++) begin : g_port
        v_tile_result_router_port u_port (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .target    (tmask[d]),
            .ack       (write_ack[d]),
            .en        (write_en[d]),
            .done_next (done_next[d])
        );
    end
endmodule

// File: tb/tb_v_tile_result_router.sv
// Directed bench for v_tile_result_router: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.

module tb_v_tile_result_router;
    localparam int DEPTH = 4;
    localparam int ND    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0][15:0] adder_outputs;
    logic [3:0]       dest_info;
    logic             adder_ack;
    logic             res_rdy;
    logic [3:0][15:0] w_data_out;
    logic [3:0]       write_en, write_rdy, write_ack;
    logic [2:0]       occupancy;
    logic             route_err;

    logic [3:0]       tag2;
    logic             ack2, res_rdy2, err2;
    logic [3:0][15:0] wdata2;
    logic [1:0]       wen2, rdy2, wack2;
    logic [2:0]       occ2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    v_tile_result_router #(.width(16), .num_inputs(4), .depth(DEPTH), .num_dests(ND)) u_dut (
        .clk(clk), .reset(rst_n), .adder_outputs(adder_outputs), .dest_info(dest_info),
        .adder_ack(adder_ack), .res_rdy(res_rdy), .w_data_out(w_data_out), .write_en(write_en),
        .write_rdy(write_rdy), .write_ack(write_ack), .occupancy(occupancy), .route_err(route_err)
    );

    v_tile_result_router #(.width(16), .num_inputs(4), .depth(DEPTH), .num_dests(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .adder_outputs(adder_outputs), .dest_info(tag2),
        .adder_ack(ack2), .res_rdy(res_rdy2), .w_data_out(wdata2), .write_en(wen2),
        .write_rdy(rdy2), .write_ack(wack2), .occupancy(occ2), .route_err(err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO as a queue, head handled as decode -> wait for
    // all targets ready -> collect acks -> pop.
    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
    } ment_t;

    ment_t       q[$];
    int          ph;
    logic [3:0]  m_tgt, m_en;
    logic [63:0] m_data;
    logic        m_err;
    bit          do_push, do_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ph = 0; m_en = '0; m_tgt = '0; m_err = 1'b0; m_data = '0;
        end else begin
            do_push = adder_ack && (q.size() < DEPTH);
            do_pop  = 1'b0;
            case (ph)
                0: if (q.size() > 0) begin
                    m_data = q[0].d;
                    if (q[0].t[3]) do_pop = 1'b1;
                    else if (q[0].t[2]) begin m_tgt = 4'hF; ph = 1; end
                    else if (int'(q[0].t[1:0]) >= ND) begin do_pop = 1'b1; m_err = 1'b1; end
                    else begin m_tgt = 4'b0001 << q[0].t[1:0]; ph = 1; end
                end
                1: if ((write_rdy & m_tgt) == m_tgt) begin m_en = m_tgt; ph = 2; end
                default: begin
                    m_en = m_en & ~write_ack;
                    if (m_en == '0) begin do_pop = 1'b1; ph = 0; end
                end
            endcase
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{adder_outputs, dest_info});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_occupancy", occupancy, q.size());
            chk("m_res_rdy", res_rdy, q.size() != DEPTH);
            chk("m_write_en", write_en, m_en);
            if (m_en != '0) chk("m_w_data_out", w_data_out, m_data);
            chk("m_route_err", route_err, m_err);
        end
    end

    logic [15:0] got[$];

    initial begin
        adder_outputs = '0; dest_info = '0; adder_ack = 0; write_rdy = '0; write_ack = '0;
        tag2 = '0; ack2 = 0; rdy2 = 2'b11; wack2 = 2'b11;
        #2;
        chk("rst_res_rdy", res_rdy, 1);
        chk("rst_write_en", write_en, 0);
        chk("rst_w_data_out", w_data_out, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_route_err", route_err, 0);
        @(negedge clk); rst_n = 1;
        step();

        // unicast to port 1
        write_rdy = 4'b0010; adder_outputs = 64'h0000_FFFF_FFFF_FFFF; dest_info = 4'b0001; adder_ack = 1;
        step(); adder_ack = 0;
        chk("uni_occ_after_capture", occupancy, 1);
        step(); chk("uni_en_t1", write_en, 0);
        step(); chk("uni_en_t2", write_en, 4'b0010);
        chk("uni_data", w_data_out, 64'h0000_FFFF_FFFF_FFFF);
        write_ack = 4'b0010;
        step(); chk("uni_en_after_ack", write_en, 0); chk("uni_occ_after_ack", occupancy, 0);
        write_ack = '0;

        // broadcast with port 2 late
        write_rdy = 4'b1011; adder_outputs = 64'h1111_2222_3333_4444; dest_info = 4'b0100; adder_ack = 1;
        step(); adder_ack = 0;
        repeat (5) begin step(); chk("bc_hold", write_en, 0); end
        write_rdy = 4'b1111;
        step(); chk("bc_all_en", write_en, 4'b1111);
        write_ack = 4'b0001;
        step(); chk("bc_ack0_en", write_en, 4'b1110); chk("bc_ack0_occ", occupancy, 1);
        write_ack = 4'b0110;
        step(); chk("bc_ack12_en", write_en, 4'b1000); chk("bc_ack12_occ", occupancy, 1);
        write_ack = 4'b1000;
        step(); chk("bc_last_en", write_en, 0); chk("bc_last_occ", occupancy, 0);
        write_ack = '0;

        // fill to full, overflow attempt, drain in order
        write_rdy = '0; dest_info = 4'b0000; adder_ack = 1;
        for (int i = 1; i <= 4; i++) begin adder_outputs = 64'(i); step(); end
        chk("full_res_rdy", res_rdy, 0); chk("full_occ", occupancy, 4);
        adder_outputs = 64'd5; step(); adder_ack = 0;
        chk("full_ignore_occ", occupancy, 4);
        write_rdy = 4'b0001; write_ack = 4'b0001; got.delete();
        for (int k = 0; k < 30; k++) begin
            step();
            if (write_en[0]) got.push_back(w_data_out[0]);
        end
        chk("drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_order", (got.size() > i) ? got[i] : 16'h0, i + 1);
        chk("drain_occ", occupancy, 0);
        write_ack = '0;

        // discards: plain, and discard bit overriding broadcast
        write_rdy = 4'hF;
        dest_info = 4'b1000; adder_outputs = 64'hDEAD; adder_ack = 1;
        step(); adder_ack = 0; chk("disc_occ1", occupancy, 1);
        step(); chk("disc_occ0", occupancy, 0); chk("disc_en", write_en, 0);
        dest_info = 4'b1110; adder_ack = 1;
        step(); adder_ack = 0;
        step(); chk("disc_bc_occ0", occupancy, 0);
        step(); chk("disc_bc_en", write_en, 0);

        // simultaneous push and pop at occupancy 2
        write_rdy = 4'b0001; write_ack = '0; dest_info = 4'b0000;
        adder_outputs = 64'hA; adder_ack = 1; step();
        adder_outputs = 64'hB; step(); adder_ack = 0;
        chk("pp_occ2", occupancy, 2);
        step(); chk("pp_en", write_en, 4'b0001);
        adder_outputs = 64'hC; adder_ack = 1; write_ack = 4'b0001;
        step(); adder_ack = 0;
        chk("pp_occ_same", occupancy, 2);
        repeat (12) step();
        chk("pp_drained", occupancy, 0);
        write_ack = '0;

        // reset in the middle of SEND
        write_rdy = 4'b0001; dest_info = 4'b0000; adder_outputs = 64'h77; adder_ack = 1;
        step(); adder_ack = 0;
        step(); step(); chk("rs_en_before", write_en, 4'b0001);
        #2 rst_n = 0;
        #1;
        chk("rs_en_async", write_en, 0); chk("rs_occ_async", occupancy, 0);
        chk("rs_res_rdy", res_rdy, 1); chk("rs_data", w_data_out, 0);
        @(negedge clk); #1 rst_n = 1;
        step();
        write_rdy = 4'b0100; dest_info = 4'b0010; adder_outputs = 64'h1234_5678_9ABC_DEF0; adder_ack = 1;
        step(); adder_ack = 0;
        step(); step(); chk("rs_new_en", write_en, 4'b0100);
        chk("rs_new_data", w_data_out, 64'h1234_5678_9ABC_DEF0);
        write_ack = 4'b0100;
        step(); chk("rs_new_done_en", write_en, 0); chk("rs_new_done_occ", occupancy, 0);
        write_ack = '0;

        // two-port instance: out-of-range unicast index
        chk("err2_clear", err2, 0);
        tag2 = 4'b0011; ack2 = 1;
        step(); ack2 = 0;
        step(); chk("err2_set", err2, 1); chk("err2_occ", occ2, 0); chk("err2_en", wen2, 0);
        tag2 = 4'b0001; ack2 = 1;
        step(); ack2 = 0;
        step(); step(); chk("err2_fwd_en", wen2, 2'b10);
        chk("err2_sticky", err2, 1);
        step(); chk("err2_fwd_occ", occ2, 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
